// File: rtl/counter_26bit_pkg.sv
// Shared constants for the counter block.
`timescale 1ns/100ps
package counter_26bit_pkg;

    localparam int COUNTER_WIDTH = 26;

endpackage

// File: rtl/counter_26bit_bit.sv
// One counter slice: half-adder feeding a DFF with synchronous clear.
`timescale 1ns/100ps
module counter_bit (
    input  logic clk,
    input  logic clr_i,
    input  logic cin_i,
    output logic q_o,
    output logic cout_o
);

    // Declaration initialiser gives a known zero at power-up with no reset pulse.
    logic q_q = 1'b0;
    logic q_d;

    assign q_d    = q_q ^ cin_i;
    assign cout_o = q_q & cin_i;
    assign q_o    = q_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/counter_26bit.sv
// Free-running WIDTH-bit up-counter built from a ripple carry chain of slices.
`timescale 1ns/100ps
module counter_26bit
    import counter_26bit_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH:0] carry;
    logic           unused_carry_out;

    // Bit 0 always receives a carry, so the chain adds one every cycle.
    assign carry[0]         = 1'b1;
    assign unused_carry_out = carry[WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
            counter_bit u_bit (
                .clk    (clk),
                .clr_i  (rst),
                .cin_i  (carry[gi]),
                .q_o    (data[gi]),
                .cout_o (carry[gi+1])
            );
        end
    endgenerate

endmodule

// File: tb/tb_counter_26bit.sv
// Bench for counter_26bit: vector table, corner sequences and random resets vs a modulo model.
`timescale 1ns/100ps
module tb_counter_26bit;

    logic        clk  = 1'b0;
    logic        rst26 = 1'b0;
    logic        rst4  = 1'b0;
    logic        rst1  = 1'b0;
    logic        rst8  = 1'b0;
    logic [25:0] d26;
    logic [3:0]  d4;
    logic [0:0]  d1;
    logic [7:0]  d8;

    counter_26bit #(.WIDTH(26)) u_w26 (.clk(clk), .rst(rst26), .data(d26));
    counter_26bit #(.WIDTH(4))  u_w4  (.clk(clk), .rst(rst4),  .data(d4));
    counter_26bit #(.WIDTH(1))  u_w1  (.clk(clk), .rst(rst1),  .data(d1));
    counter_26bit #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst8),  .data(d8));

    always #1 clk = ~clk;

    typedef struct {
        bit     rst;
        longint exp;
    } vec_t;

    vec_t   vec[$];
    longint m26 = 0, m4 = 0, m1 = 0, m8 = 0;
    int     checks = 0;
    int     passes = 0;
    int     edge_n = 0;

    // Value after an edge: zero under reset, otherwise previous + 1 modulo 2^w.
    function automatic longint nxt(longint cur, bit r, int w);
        longint modulus;
        modulus = longint'(1) << w;
        return r ? 64'sd0 : (cur + 1) % modulus;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic step(input bit r26, input bit r4, input bit r1, input bit r8);
        rst26 = r26;
        rst4  = r4;
        rst1  = r1;
        rst8  = r8;
        @(posedge clk);
        edge_n++;
        m26 = nxt(m26, r26, 26);
        m4  = nxt(m4,  r4,  4);
        m1  = nxt(m1,  r1,  1);
        m8  = nxt(m8,  r8,  8);
        @(negedge clk);
        $display("edge %0d rst=%b%b%b%b data26=%0d data4=%0d data1=%0d data8=%0d",
                 edge_n, r26, r4, r1, r8, d26, d4, d1, d8);
        check("model_w26", longint'(d26), m26);
        check("model_w4",  longint'(d4),  m4);
        check("model_w1",  longint'(d1),  m1);
        check("model_w8",  longint'(d8),  m8);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        // Free count to 37, reset for 3 edges, then 50 more edges from zero.
        for (int i = 1; i <= 37; i++) vec.push_back('{rst: 1'b0, exp: longint'(i)});
        for (int i = 0; i < 3; i++)   vec.push_back('{rst: 1'b1, exp: 64'sd0});
        for (int i = 1; i <= 50; i++) vec.push_back('{rst: 1'b0, exp: longint'(i)});

        #0.5;
        check("powerup_w26", longint'(d26), 0);
        check("powerup_w4",  longint'(d4),  0);
        check("powerup_w1",  longint'(d1),  0);
        check("powerup_w8",  longint'(d8),  0);

        for (int i = 0; i < vec.size(); i++) begin
            step(vec[i].rst, 1'b0, 1'b0, 1'b0);
            check("vec_w26", longint'(d26), vec[i].exp);
        end

        // WIDTH=4 wrap: 14 -> 15 -> 0 -> 1.
        for (int i = 0; i < 20 && d4 != 4'd14; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w4_preload14", longint'(d4), 14);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w4_to15", longint'(d4), 15);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w4_wrap0", longint'(d4), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w4_after1", longint'(d4), 1);

        // Reset on the edge where the count sits at full scale.
        for (int i = 0; i < 20 && d4 != 4'd15; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w4_full15", longint'(d4), 15);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("w4_rst_at_full", longint'(d4), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w4_rst_release1", longint'(d4), 1);

        // WIDTH=1 toggles.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("w1_rst0", longint'(d1), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w1_t1", longint'(d1), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w1_t0", longint'(d1), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w1_t1b", longint'(d1), 1);

        // WIDTH=8 reaches 255 after 255 edges from reset, then 0 on the 256th.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("w8_rst0", longint'(d8), 0);
        for (int i = 0; i < 255; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w8_full255", longint'(d8), 255);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("w8_wrap0", longint'(d8), 0);

        // Random reset pattern on every instance, checked by the model inside step.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
